// File: rtl/cg_pkg.sv
// Shared types and default constants for the activity-driven clock-gate enable controller.
package cg_pkg;

  typedef enum logic [1:0] {
    CG_GATED = 2'd0,
    CG_WAKE  = 2'd1,
    CG_RUN   = 2'd2
  } cg_state_e;

  localparam int unsigned CG_IDLE_CYCLES = 8;
  localparam int unsigned CG_WAKE_CYCLES = 2;

endpackage

// File: rtl/cg_idle_timer.sv
// Clear/increment idle counter with a terminal-count flag at IDLE_CYCLES-1.
module cg_idle_timer #(
  parameter int unsigned IDLE_CYCLES = cg_pkg::CG_IDLE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc_c
);

  localparam int unsigned CNT_W = $clog2(IDLE_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;

  // Clear has priority; the counter never passes IDLE_CYCLES-1 because tc forces a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tc_c = (r_cnt == CNT_W'(IDLE_CYCLES - 1));

endmodule

// File: rtl/cg_enable_ctrl.sv
// Gate-enable generator: wakes on activity, accepts data after a wake latency,
// and drops the enable after a run of idle cycles.
module cg_enable_ctrl
  import cg_pkg::*;
#(
  parameter int unsigned DATA_W      = 4,
  parameter int unsigned IDLE_CYCLES = CG_IDLE_CYCLES,
  parameter int unsigned WAKE_CYCLES = CG_WAKE_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              force_on,
  output logic              en,
  output logic [DATA_W-1:0] din,
  output logic              gated
);

  localparam int unsigned WAKE_W = $clog2(WAKE_CYCLES + 1);

  cg_state_e         r_state;
  logic [WAKE_W-1:0] r_wake_cnt;
  logic              r_en;
  logic              r_ready;
  logic              r_gated;
  logic [DATA_W-1:0] r_din;

  logic w_idle;
  logic w_idle_tc;

  assign w_idle = (r_state == CG_RUN) & ~in_valid & ~force_on;

  cg_idle_timer #(
    .IDLE_CYCLES (IDLE_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (~w_idle | w_idle_tc),
    .i_inc  (w_idle & ~w_idle_tc),
    .o_tc_c (w_idle_tc)
  );

  // State and registered outputs move together so en/in_ready/gated are glitch-free flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= CG_GATED;
      r_wake_cnt <= '0;
      r_en       <= 1'b0;
      r_ready    <= 1'b0;
      r_gated    <= 1'b1;
    end else begin
      case (r_state)
        CG_GATED: begin
          if (in_valid | force_on) begin
            r_state    <= CG_WAKE;
            r_en       <= 1'b1;
            r_gated    <= 1'b0;
            r_wake_cnt <= WAKE_W'(WAKE_CYCLES - 1);
          end
        end
        CG_WAKE: begin
          if (r_wake_cnt == '0) begin
            r_state <= CG_RUN;
            r_ready <= 1'b1;
          end else begin
            r_wake_cnt <= r_wake_cnt - WAKE_W'(1);
          end
        end
        CG_RUN: begin
          if (w_idle && w_idle_tc) begin
            r_state <= CG_GATED;
            r_en    <= 1'b0;
            r_ready <= 1'b0;
            r_gated <= 1'b1;
          end
        end
        default: begin
          r_state <= CG_GATED;
          r_en    <= 1'b0;
          r_ready <= 1'b0;
          r_gated <= 1'b1;
        end
      endcase
    end
  end

  // Data register only loads on an accepted handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_din <= '0;
    end else if (in_valid && r_ready) begin
      r_din <= in_data;
    end
  end

  assign en       = r_en;
  assign in_ready = r_ready;
  assign gated    = r_gated;
  assign din      = r_din;

endmodule
